aes_decrypt: RTL
================

# aes_decrypt

Iterative AES-256 decryption core: the receive-side counterpart of `AESEncrypt`, using the same `ready`/`data_in`/`key`/`data_out`/`valid` convention. For each accepted block it expands the 256-bit key into 15 round keys, one word per cycle. It then applies the inverse cipher, one round per cycle, and emits the 128-bit plaintext with a one-cycle `valid` pulse.

## Interface
- No parameters. AES-256 is fixed: Nk=8, Nr=14.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ready  in  1  start request; sampled only in IDLE.
- data_in  in  128  ciphertext; [127:120] is byte 0 of the FIPS-197 block.
- key  in  256  cipher key; [255:248] is key byte 0.
- data_out  out  128  plaintext; holds its value until the next completion.
- valid  out  1  one-cycle pulse; data_out is new in that cycle.
- busy  out  1  high from the accept edge until the edge that raises valid.

## Operation
- **States:** IDLE, EXPAND, ROUND.
- **IDLE:**
  - If ready=1 at an edge, latch data_in into state_reg.
  - Load words w[0..7] from key (w[0] = key[255:224]).
  - Set widx=8, go to EXPAND, set busy=1.
- **EXPAND:**
  - Compute one word per cycle into w[widx]; increment widx.
  - If widx%8==0: w = w[i-8] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/8].
  - If widx%8==4: w = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w = w[i-8] ^ w[i-1].
  - After widx=59 is written, set rnd=14 and go to ROUND.
  - Round keys are stored as rk[r] = {w[4r], …, w[4r+3]}, r = 0..14, in a 15×128 register array.
- **ROUND** (rnd counts down 14 → 0):
  - rnd=14: state ^= rk[14].
  - 13 ≥ rnd ≥ 1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]).
  - rnd=0: data_out = InvSubBytes(InvShiftRows(state)) ^ rk[0]. Set valid=1, busy=0, go to IDLE.
- ready while busy is ignored. It is not queued.
- ready held high re-accepts on the first IDLE edge after completion.
- A new key is expanded on every accept. No round-key caching.
- Arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are {0e,0b,0d,09}.

## Timing
- **Reset values:** state=IDLE, valid=0, busy=0, data_out=0, counters=0. Round-key array and state_reg are not reset.
- **Latency:**
  - Accept edge = E0.
  - Expansion writes occur at E1..E52.
  - Rounds occur at E53..E67.
  - valid is high in the cycle following E67, i.e. 67 cycles after accept.
- **Throughput:** minimum accept-to-accept spacing is 68 cycles; the earliest next accept is at E68 with ready=1.
- valid is high for exactly one cycle. data_out changes only at the completion edge or on reset.
- **Reset mid-operation:** takes effect at the next edge regardless of state. It aborts the block with no valid pulse and clears data_out to 0.
- **Reset together with ready:** reset wins; nothing is accepted.
- data_in and key must be stable only at the accept edge. They are don't-care afterwards.

## Structure
- Package `aes_pkg` holds:
  - the `sbox[256]` and `inv_sbox[256]` constants and `rcon[1..7]`;
  - functions `xtime`, `gmul`, `sub_word`, `rot_word`;
  - the state enum `aes_dec_state_t` and `localparam NR=14`, `NK=8`.
- Sub-module `aes_inv_round`, purely combinational: inputs state, rk, last. It outputs InvShiftRows → InvSubBytes → AddRoundKey, followed by InvMixColumns unless `last`. `aes_decrypt` holds the FSM, counters, key expansion, round-key array and output registers.

## Test plan
- **FIPS-197 C.3:** key 000102…1e1f, data_in 8ea2b7ca516745bfeafc49904b496089, ready pulsed 1 cycle → valid exactly 67 cycles later, data_out = 00112233445566778899aabbccddeeff, busy drops at the same edge.
- **All-zero key:** data_in dc95c078a2408989ad48a21492842087 → data_out 0. Then a second block with the FIPS key (the key changes between blocks) → correct plaintext, proving re-expansion.
- **ready held high for 200 cycles:** the same block is accepted at E0, E68 and E136 → valid pulses at cycles 67, 135 and 203 only.
- **Toggle data_in/key and pulse ready** during EXPAND and during ROUND of a FIPS block → output is unchanged at 00112233…eeff with a single valid pulse.
- **Reset at E30 (EXPAND) and at E60 (ROUND):** valid, busy and data_out are 0 from the next cycle and no valid pulse follows. A fresh accept afterwards decrypts correctly.
- **Reset asserted at the same edge as ready:** no accept and busy stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the AES-256 decryption core.
package aes_pkg;

  localparam int NR = 14;
  localparam int NK = 8;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND} aes_dec_state_t;

  localparam logic [7:0] sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Entry 0 is unused; expansion only indexes 1..7.
  localparam logic [7:0] rcon [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [7:0] ak [16];
  logic [7:0] mc [16];

  // Byte k of the block sits at [127-8k -: 8]; row = k%4, column = k/4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int Src = 4 * ((c - r + 4) % 4) + r;
      localparam int Dst = 4 * c + r;
      assign ak[Dst] = inv_sbox[state_i[127-8*Src -: 8]] ^ rk_i[127-8*Dst -: 8];
      assign state_o[127-8*Dst -: 8] = last_i ? ak[Dst] : mc[Dst];
    end
    assign mc[4*c+0] = gmul(ak[4*c], 8'h0e) ^ gmul(ak[4*c+1], 8'h0b) ^
                       gmul(ak[4*c+2], 8'h0d) ^ gmul(ak[4*c+3], 8'h09);
    assign mc[4*c+1] = gmul(ak[4*c], 8'h09) ^ gmul(ak[4*c+1], 8'h0e) ^
                       gmul(ak[4*c+2], 8'h0b) ^ gmul(ak[4*c+3], 8'h0d);
    assign mc[4*c+2] = gmul(ak[4*c], 8'h0d) ^ gmul(ak[4*c+1], 8'h09) ^
                       gmul(ak[4*c+2], 8'h0e) ^ gmul(ak[4*c+3], 8'h0b);
    assign mc[4*c+3] = gmul(ak[4*c], 8'h0b) ^ gmul(ak[4*c+1], 8'h0d) ^
                       gmul(ak[4*c+2], 8'h09) ^ gmul(ak[4*c+3], 8'h0e);
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-256 decryption: key expansion one word per cycle into the
// round-key array, then one inverse round per cycle; valid pulses on completion.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         ready,
  input  logic [127:0] data_in,
  input  logic [255:0] key,
  output logic [127:0] data_out,
  output logic         valid,
  output logic         busy
);

  aes_dec_state_t state_q, state_d;
  logic [5:0]   widx_q, widx_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic [127:0] dout_q, dout_d;
  logic         accept, exp_we, blk_we;

  logic [127:0] blk_q;
  logic [127:0] rk_q [NR+1];

  logic [5:0]   widx_m1, widx_m8;
  logic [31:0]  w_prev, w_back8, w_tmp, w_new;
  logic [127:0] round_out;

  function automatic logic [31:0] word_get(input logic [127:0] row, input logic [1:0] k);
    case (k)
      2'd0:    return row[127:96];
      2'd1:    return row[95:64];
      2'd2:    return row[63:32];
      default: return row[31:0];
    endcase
  endfunction

  function automatic logic [127:0] word_put(input logic [127:0] row, input logic [1:0] k,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = row;
    case (k)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // Key expansion reads w[i-1] and w[i-8] straight out of the round-key array.
  assign widx_m1 = widx_q - 6'd1;
  assign widx_m8 = widx_q - 6'd8;
  assign w_prev  = word_get(rk_q[widx_m1[5:2]], widx_m1[1:0]);
  assign w_back8 = word_get(rk_q[widx_m8[5:2]], widx_m8[1:0]);

  always_comb begin
    case (widx_q[2:0])
      3'd0:    w_tmp = sub_word(rot_word(w_prev)) ^ {rcon[widx_q[5:3]], 24'h000000};
      3'd4:    w_tmp = sub_word(w_prev);
      default: w_tmp = w_prev;
    endcase
  end

  assign w_new = w_back8 ^ w_tmp;

  aes_inv_round u_round (
    .state_i (blk_q),
    .rk_i    (rk_q[rnd_q]),
    .last_i  (rnd_q == 4'd0),
    .state_o (round_out)
  );

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    dout_d  = dout_q;
    accept  = 1'b0;
    exp_we  = 1'b0;
    blk_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready && !reset) begin
          accept  = 1'b1;
          widx_d  = 6'd8;
          busy_d  = 1'b1;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        exp_we = 1'b1;
        widx_d = widx_q + 6'd1;
        if (widx_q == 6'd59) begin
          rnd_d   = 4'd14;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_q == 4'd0) begin
          dout_d  = round_out;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          blk_we = 1'b1;
          rnd_d  = rnd_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  // Round keys and the working block carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_q   <= data_in;
      rk_q[0] <= key[255:128];
      rk_q[1] <= key[127:0];
    end
    if (exp_we) rk_q[widx_q[5:2]] <= word_put(rk_q[widx_q[5:2]], widx_q[1:0], w_new);
    if (blk_we) blk_q <= (rnd_q == 4'd14) ? (blk_q ^ rk_q[NR]) : round_out;
  end

  assign data_out = dout_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule
